// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder.
// The sub line exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;

    modport master (
        output start, a, b, cin,
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        input  busy, done, sum, carry
    );

    modport slave (
        input  start, a, b, cin,
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        output busy, done, sum, carry
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-add step per clock, WIDTH cycles per result.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b with not-borrow on carry).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sa, sb, ps_nx, sum_r, b_ld;
    logic [CW-1:0]    cnt;
    logic             c, c_nx, c_ld, s, carry_r, accept, last;

    assign accept = bus.start && (state == IDLE || state == DONE);
    assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));
    assign s      = sa[0] ^ sb[0] ^ c;
    assign c_nx   = (sa[0] & sb[0]) | (c & (sa[0] ^ sb[0]));

`ifdef SERIAL_ADDER_SUB_EN
    // Subtract as a + ~b + 1; cin is ignored while sub is set.
    assign b_ld = bus.sub ? ~bus.b : bus.b;
    assign c_ld = bus.sub | bus.cin;
`else
    assign b_ld = bus.b;
    assign c_ld = bus.cin;
`endif

    // Only WIDTH-1 earlier bits need storage; the newest bit joins on the final edge.
    if (WIDTH == 1) begin : g_w1
        assign ps_nx = s;
    end else begin : g_wn
        logic [WIDTH-2:0] ps;
        always_ff @(posedge clk or posedge rst) begin
            if (rst)                ps <= '0;
            else if (state == RUN)  ps <= ps_nx[WIDTH-1:1];
        end
        assign ps_nx = {s, ps};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: the default assignment first keeps this block combinational (no latch).
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    state_nx = bus.start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa      <= '0;
            sb      <= '0;
            c       <= 1'b0;
            cnt     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
        end else if (accept) begin
            sa  <= bus.a;
            sb  <= b_ld;
            c   <= c_ld;
            cnt <= '0;
        end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            c   <= c_nx;
            cnt <= cnt + 1'b1;
            // Result registers move only here, so they hold across idle and later runs.
            if (last) begin
                sum_r   <= ps_nx;
                carry_r <= c_nx;
            end
        end
    end

    assign bus.busy  = (state == RUN);
    assign bus.done  = (state == DONE);
    assign bus.sum   = sum_r;
    assign bus.carry = carry_r;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit and a 1-bit instance share clk/rst.
// Subtract vectors run only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) if8 ();
    serial_adder_if #(.WIDTH(1)) if1 ();

    serial_adder #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(if8.slave));
    serial_adder #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge where done is seen (or the bound expires).
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                        output int lat, output int busy_cnt);
        if8.a = ta; if8.b = tb_v; if8.cin = tc; if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        if8.a = 8'($urandom); if8.b = 8'($urandom); if8.cin = 1'($urandom);
        lat = 0; busy_cnt = 0;
        while (!if8.done && lat < 40) begin
            if (if8.busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run1(input logic ta, input logic tb_v, input logic tc, output int lat);
        if1.a = ta; if1.b = tb_v; if1.cin = tc; if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        lat = 0;
        while (!if1.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, bc, ndone;
        if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
        if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        if8.sub = 1'b0; if1.sub = 1'b0;
`endif
        #1;
        check("rst_busy",  32'(if8.busy),  0);
        check("rst_done",  32'(if8.done),  0);
        check("rst_sum",   32'(if8.sum),   0);
        check("rst_carry", 32'(if8.carry), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Zero operands: latency and busy length.
        run8(8'h00, 8'h00, 1'b0, lat, bc);
        check("z_lat",   32'(lat),       8);
        check("z_busy",  32'(bc),        8);
        check("z_sum",   32'(if8.sum),   32'h00);
        check("z_carry", 32'(if8.carry), 0);
        @(negedge clk);
        check("z_done_strobe", 32'(if8.done), 0);
        check("z_idle_busy",   32'(if8.busy), 0);

        // Overflow, then back-to-back start held in DONE.
        run8(8'hFF, 8'h01, 1'b0, lat, bc);
        check("ovf_sum",   32'(if8.sum),   32'h00);
        check("ovf_carry", 32'(if8.carry), 1);
        run8(8'hA5, 8'h5A, 1'b1, lat, bc);
        check("b2b_gap",   32'(lat + 1),   9);
        check("b2b_sum",   32'(if8.sum),   32'h00);
        check("b2b_carry", 32'(if8.carry), 1);
        @(negedge clk);

        // Starts during RUN are ignored; result holds until the run ends.
        if8.a = 8'h12; if8.b = 8'h34; if8.cin = 1'b0; if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        ndone = 0; lat = -1;
        for (int k = 1; k <= 20; k++) begin
            if (k == 3 || k == 7) begin
                if8.a = 8'hFF; if8.b = 8'hFF; if8.cin = 1'b1; if8.start = 1'b1;
            end
            if (k == 3) check("hold_sum", 32'(if8.sum), 32'h00);
            @(negedge clk);
            if8.start = 1'b0;
            if (if8.done) begin
                ndone++;
                if (lat < 0) lat = k;
            end
        end
        check("ign_lat",   32'(lat),       8);
        check("ign_ndone", 32'(ndone),     1);
        check("ign_sum",   32'(if8.sum),   32'h46);
        check("ign_carry", 32'(if8.carry), 0);

        // Nonzero result, then reset mid-run clears it.
        run8(8'h80, 8'h81, 1'b0, lat, bc);
        check("pre_sum",   32'(if8.sum),   32'h01);
        check("pre_carry", 32'(if8.carry), 1);
        @(negedge clk);
        if8.a = 8'hFF; if8.b = 8'h01; if8.cin = 1'b0; if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy",  32'(if8.busy),  0);
        check("arst_done",  32'(if8.done),  0);
        check("arst_sum",   32'(if8.sum),   0);
        check("arst_carry", 32'(if8.carry), 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (if8.done || if8.busy) ndone++;
        end
        check("arst_no_done", 32'(ndone), 0);
        run8(8'h03, 8'h04, 1'b0, lat, bc);
        check("post_lat",   32'(lat),       8);
        check("post_sum",   32'(if8.sum),   32'h07);
        check("post_carry", 32'(if8.carry), 0);
        @(negedge clk);

        // WIDTH=1 truth table.
        run1(1'b1, 1'b1, 1'b0, lat);
        check("w1_11_lat",   32'(lat),       1);
        check("w1_11_sum",   32'(if1.sum),   0);
        check("w1_11_carry", 32'(if1.carry), 1);
        @(negedge clk);
        run1(1'b1, 1'b0, 1'b0, lat);
        check("w1_10_sum",   32'(if1.sum),   1);
        check("w1_10_carry", 32'(if1.carry), 0);
        @(negedge clk);
        run1(1'b1, 1'b1, 1'b1, lat);
        check("w1_111_sum",   32'(if1.sum),   1);
        check("w1_111_carry", 32'(if1.carry), 1);
        @(negedge clk);

`ifdef SERIAL_ADDER_SUB_EN
        if8.sub = 1'b1;
        run8(8'h10, 8'h01, 1'b0, lat, bc);
        check("sub_10_01_sum",   32'(if8.sum),   32'h0F);
        check("sub_10_01_carry", 32'(if8.carry), 1);
        @(negedge clk);
        if8.sub = 1'b1;
        run8(8'h01, 8'h02, 1'b0, lat, bc);
        check("sub_01_02_sum",   32'(if8.sum),   32'hFF);
        check("sub_01_02_carry", 32'(if8.carry), 0);
        @(negedge clk);
        if8.sub = 1'b1;
        run8(8'h10, 8'h01, 1'b1, lat, bc);
        check("sub_cin_sum",   32'(if8.sum),   32'h0F);
        check("sub_cin_carry", 32'(if8.carry), 1);
        @(negedge clk);
        if8.sub = 1'b0;
        run8(8'h05, 8'h03, 1'b1, lat, bc);
        check("sub0_sum",   32'(if8.sum),   32'h09);
        check("sub0_carry", 32'(if8.carry), 0);
        @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
